line_rng_ctrl: RTL
==================

LINE_RNG_CTRL -- requirements
Module: line_rng_ctrl

Interface
REQ-001 SHALL have parameter HSZ_WD, default 12, width of the line-length and pixel-counter fields.
REQ-002 SHALL have parameter VSZ_WD, default 12, width of the line-count and line-counter fields.
REQ-003 SHALL have parameter BLK_WD, default 8, width of the horizontal-blank field.
REQ-004 SHALL have port clk  input  1  clock; single clock domain, all logic rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_start  input  1  frame start request, level-sampled.
REQ-007 SHALL have port i_hsize  input  HSZ_WD  active pixels per line.
REQ-008 SHALL have port i_vsize  input  VSZ_WD  lines per frame.
REQ-009 SHALL have port i_hblk  input  BLK_WD  blank cycles between lines.
REQ-010 SHALL have port i_hold  input  1  downstream hold; extends blanking.
REQ-011 SHALL have port o_href  output  1  active pixel strobe to line-range datapath.
REQ-012 SHALL have ports o_hstr, o_hend, o_vstr, o_vend  output  1 each  line/frame start/end pulses.
REQ-013 SHALL have ports o_busy and o_done  output  1 each  frame in progress / frame complete pulse.

Function
REQ-014 SHALL implement FSM states IDLE, HACT, HBLK, DONE; one-hot encoding.
REQ-015 In IDLE, i_start=1 with i_hsize!=0 and i_vsize!=0 SHALL latch hsize/vsize/hblk and enter HACT next cycle, with pixel and line counters at 0.
REQ-016 i_start with a zero size SHALL be ignored; i_start outside IDLE SHALL be ignored.
REQ-017 Config inputs SHALL be used only at acceptance; later changes do not affect the running frame.
REQ-018 In HACT: o_href=1 every cycle; pixel counter increments; o_hstr=1 at pixel 0; o_hend=1 at pixel hsize-1.
REQ-019 o_vstr SHALL equal o_hstr on line 0 only; o_vend SHALL equal o_hend on line vsize-1 only.
REQ-020 At pixel hsize-1: if line < vsize-1, enter HBLK and increment line; otherwise enter DONE.
REQ-021 HBLK SHALL last max(hblk,1) cycles, then enter HACT at pixel 0 unless i_hold=1; while i_hold=1 SHALL remain in HBLK.
REQ-022 i_hold SHALL have no effect in HACT, DONE or IDLE; a line is never interrupted.
REQ-023 DONE SHALL last exactly 1 cycle with o_done=1, then enter IDLE.
REQ-024 o_busy SHALL be 1 in HACT, HBLK and DONE, and 0 in IDLE.
REQ-025 All outputs SHALL be registered/state-decoded with no combinational path from any input.
REQ-026 Counters SHALL not wrap: hsize=2^HSZ_WD-1 and vsize=2^VSZ_WD-1 SHALL complete correctly.

Reset
REQ-027 rst=1 SHALL, at the next edge, force IDLE, clear counters and latched config, and drive every output to 0.
REQ-028 rst asserted mid-frame SHALL abort with no o_vend or o_done pulse; the next frame needs a new i_start.

Configuration
REQ-029 Macro LINE_RNG_CTRL_ERR_EN, when defined, SHALL add input i_err_clr (1) and output o_err (1).
REQ-030 With the macro, o_err SHALL set one cycle after i_start arrives with a zero size or while o_busy=1, and hold until i_err_clr=1 or rst.
REQ-031 With the macro, set has priority over clear in the same cycle.
REQ-032 Without the macro, the i_err_clr and o_err ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Basic frame: hsize=4, vsize=2, hblk=3, i_start at cycle 0 -> href cycles 1-4 and 8-11; vstr/hstr@1; hend@4; hstr@8; hend/vend@11; done@12; busy 1-12.
REQ-034 Zero blank: hsize=2, vsize=3, hblk=0 -> href 1-2, 4-5, 7-8; one blank cycle each at 3 and 6; done@9.
REQ-035 Hold: basic frame with i_hold=1 cycles 5-9 -> second line href 11-14; vend@14; done@15.
REQ-036 Zero size and restart: i_start with vsize=0 -> busy stays 0; i_start at cycle 3 of a running frame -> ignored, frame timing unchanged; o_err=1 at the next cycle when LINE_RNG_CTRL_ERR_EN is defined.
REQ-037 Reset mid-frame: rst at cycle 6 of the basic frame -> all outputs 0 from cycle 7, no vend/done; new i_start at cycle 9 -> href from cycle 10.

Source files
------------

// File: rtl/line_rng_ctrl.sv
// Line/frame range controller: sequences active-pixel and blanking intervals for one frame per start request.
// Optional error flag for ignored start requests is enabled by defining LINE_RNG_CTRL_ERR_EN.
module line_rng_ctrl #(
    parameter int unsigned HSZ_WD = 12,
    parameter int unsigned VSZ_WD = 12,
    parameter int unsigned BLK_WD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [HSZ_WD-1:0] i_hsize,
    input  logic [VSZ_WD-1:0] i_vsize,
    input  logic [BLK_WD-1:0] i_hblk,
    input  logic              i_hold,
`ifdef LINE_RNG_CTRL_ERR_EN
    input  logic              i_err_clr,
    output logic              o_err,
`endif
    output logic              o_href,
    output logic              o_hstr,
    output logic              o_hend,
    output logic              o_vstr,
    output logic              o_vend,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned BCW = BLK_WD + 1;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_HACT = 4'b0010,
        S_HBLK = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HSZ_WD-1:0] r_hsize;
    logic [VSZ_WD-1:0] r_vsize;
    logic [BLK_WD-1:0] r_hblk;
    logic [HSZ_WD-1:0] r_pix;
    logic [VSZ_WD-1:0] r_line;
    logic [BLK_WD-1:0] r_bcnt;

    logic              w_size_ok;
    logic              w_accept;
    logic              w_pix_last;
    logic              w_line_last;
    logic [BCW-1:0]    w_bcnt_inc;
    logic              w_blk_last;

    assign w_size_ok   = (i_hsize != '0) && (i_vsize != '0);
    assign w_accept    = i_start && w_size_ok && (r_state == S_IDLE);
    assign w_pix_last  = (r_pix == (r_hsize - HSZ_WD'(1)));
    assign w_line_last = (r_line == (r_vsize - VSZ_WD'(1)));
    // Blank length is max(hblk,1): a zero field still gives one blank cycle.
    assign w_bcnt_inc  = {1'b0, r_bcnt} + BCW'(1);
    assign w_blk_last  = (w_bcnt_inc >= {1'b0, r_hblk});

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_HACT;
                end
            end
            S_HACT: begin
                if (w_pix_last) begin
                    w_state_nxt = w_line_last ? S_DONE : S_HBLK;
                end
            end
            S_HBLK: begin
                if (w_blk_last && !i_hold) begin
                    w_state_nxt = S_HACT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Config latch and pixel/line/blank counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsize <= '0;
            r_vsize <= '0;
            r_hblk  <= '0;
            r_pix   <= '0;
            r_line  <= '0;
            r_bcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_hsize <= i_hsize;
                        r_vsize <= i_vsize;
                        r_hblk  <= i_hblk;
                        r_pix   <= '0;
                        r_line  <= '0;
                        r_bcnt  <= '0;
                    end
                end
                S_HACT: begin
                    if (w_pix_last) begin
                        r_pix  <= '0;
                        r_bcnt <= '0;
                        if (!w_line_last) begin
                            r_line <= r_line + VSZ_WD'(1);
                        end
                    end else begin
                        r_pix <= r_pix + HSZ_WD'(1);
                    end
                end
                S_HBLK: begin
                    // Saturates so an arbitrarily long hold cannot wrap the count.
                    if (!w_blk_last) begin
                        r_bcnt <= r_bcnt + BLK_WD'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_href = (r_state == S_HACT);
    assign o_hstr = o_href && (r_pix == '0);
    assign o_hend = o_href && w_pix_last;
    assign o_vstr = o_hstr && (r_line == '0);
    assign o_vend = o_hend && w_line_last;
    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_DONE);

`ifdef LINE_RNG_CTRL_ERR_EN
    logic r_err;

    // Sticky flag for a start request that was dropped; set wins over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (i_start && (!w_size_ok || (r_state != S_IDLE))) begin
            r_err <= 1'b1;
        end else if (i_err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign o_err = r_err;
`endif

endmodule
